// File: rtl/cic_comb_log.sv
// CIC comb stage for interleaved column slots, followed by power and log-intensity pixel mapping.
// Optional macro SPEC_HEAT_PALETTE_EN selects a heat-map palette instead of grayscale.
module cic_comb_log #(
    parameter int DW         = 54,
    parameter int SLOTS_LOG2 = 5,
    parameter int SEL_HI     = 41,
    parameter int SQ_HI      = 34
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [SLOTS_LOG2-1:0]   in_slot,
    input  logic signed [DW-1:0]    in_re,
    input  logic signed [DW-1:0]    in_im,
    output logic                    out_valid,
    output logic [SLOTS_LOG2-1:0]   out_slot,
    output logic [35:0]             out_pow,
    output logic [5:0]              out_level,
    output logic [15:0]             out_rgb565
);

    localparam int NSLOT = 1 << SLOTS_LOG2;
    localparam int SH    = SEL_HI - 17;
    localparam int LO    = SQ_HI - 15;

    logic [DW-1:0]         memRe [NSLOT];
    logic [DW-1:0]         memIm [NSLOT];
    logic [NSLOT-1:0]      primed_q, primed_d;

    logic                  v1_q, pr1_q, v2_q, v3_q;
    logic [SLOTS_LOG2-1:0] slot1_q, slot2_q, slot3_q;
    logic [DW-1:0]         re1_q, im1_q, pre1_q, pim1_q;
    logic [DW-1:0]         dre2_q, dim2_q;
    logic signed [17:0]    sre3_q, sim3_q;

    logic                  wasPrimed, fwd;
    logic [DW-1:0]         prevRe, prevIm;
    logic signed [35:0]    reX, imX, pRe, pIm;
    logic [35:0]           powD;
    logic [5:0]            levelD;
    logic [15:0]           rgbD;
    logic                  unusedLowBits;

    function automatic logic signed [17:0] satSlice(input logic [DW-1:0] d);
        logic [DW-SEL_HI-1:0] top;
        top = d[DW-1:SEL_HI];
        if (top == '0 || top == '1)
            return d[SEL_HI -: 18];
        else if (d[DW-1])
            return 18'sh20000;
        else
            return 18'sh1FFFF;
    endfunction

    // A flush wipes history first, so a concurrent sample always lands as unprimed.
    always_comb begin
        primed_d = primed_q;
        if (flush)
            primed_d = '0;
        if (in_valid)
            primed_d[in_slot] = 1'b1;
        wasPrimed = primed_q[in_slot] & ~flush;
        fwd       = v1_q && (slot1_q == in_slot);
        prevRe    = fwd ? re1_q : memRe[in_slot];
        prevIm    = fwd ? im1_q : memIm[in_slot];
    end

    always_comb begin
        reX    = {{18{sre3_q[17]}}, sre3_q};
        imX    = {{18{sim3_q[17]}}, sim3_q};
        pRe    = reX * reX;
        pIm    = imX * imX;
        powD   = pRe + pIm;
        levelD = 6'd0;
        if (|powD[35:SQ_HI+1]) begin
            levelD = 6'd63;
        end else begin
            for (int b = LO; b <= SQ_HI; b++)
                if (powD[b])
                    levelD = 6'(4 * (b - LO) + 2);
        end
`ifdef SPEC_HEAT_PALETTE_EN
        if (levelD == 6'd63)
            rgbD = 16'hFFFF;
        else
            rgbD = {levelD[5:1],
                    (levelD[5] ? levelD[4:0] : 5'd0), 1'b0,
                    (levelD[5] ? 5'd0 : levelD[4:0])};
`else
        rgbD = {levelD[5:1], levelD, levelD[5:1]};
`endif
    end

    assign unusedLowBits = ^{dre2_q[SH-1:0], dim2_q[SH-1:0]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            primed_q   <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            out_valid  <= 1'b0;
            out_slot   <= '0;
            out_pow    <= '0;
            out_level  <= '0;
            out_rgb565 <= '0;
        end else begin
            primed_q  <= primed_d;
            v1_q      <= in_valid;
            v2_q      <= v1_q & pr1_q;
            v3_q      <= v2_q;
            out_valid <= v3_q;
            if (v3_q) begin
                out_slot   <= slot3_q;
                out_pow    <= powD;
                out_level  <= levelD;
                out_rgb565 <= rgbD;
            end
        end
    end

    // Delay memory and datapath registers carry no reset; the valid chain and primed bits gate them.
    always_ff @(posedge CLK) begin
        slot1_q <= in_slot;
        re1_q   <= in_re;
        im1_q   <= in_im;
        pre1_q  <= prevRe;
        pim1_q  <= prevIm;
        pr1_q   <= wasPrimed;
        if (v1_q) begin
            memRe[slot1_q] <= re1_q;
            memIm[slot1_q] <= im1_q;
        end
        slot2_q <= slot1_q;
        dre2_q  <= re1_q - pre1_q;
        dim2_q  <= im1_q - pim1_q;
        slot3_q <= slot2_q;
        sre3_q  <= satSlice(dre2_q);
        sim3_q  <= satSlice(dim2_q);
    end

endmodule

// File: tb/tb_cic_comb_log.sv
// Randomized self-checking bench for cic_comb_log against a per-slot arithmetic reference model.
// Honors SPEC_HEAT_PALETTE_EN the same way as the design.
module tb_cic_comb_log;

    localparam int DW     = 54;
    localparam int NS     = 32;
    localparam int SEL_HI = 41;
    localparam int SQ_HI  = 34;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [4:0]    in_slot = '0;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic          out_valid;
    logic [4:0]    out_slot;
    logic [35:0]   out_pow;
    logic [5:0]    out_level;
    logic [15:0]   out_rgb565;

    cic_comb_log #(.DW(DW), .SLOTS_LOG2(5), .SEL_HI(SEL_HI), .SQ_HI(SQ_HI)) dut (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_slot(in_slot),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_slot(out_slot),
        .out_pow(out_pow), .out_level(out_level), .out_rgb565(out_rgb565)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          due;
        int          slot;
        longint      pow;
        int          level;
        logic [15:0] rgb;
    } res_t;

    res_t        pend[$];
    longint      memRe [NS];
    longint      memIm [NS];
    bit          primed [NS];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        expValid;
    int          expSlot;
    longint      expPow;
    int          expLevel;
    logic [15:0] expRgb;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic longint wrapDw(input longint x);
        return (x <<< (64 - DW)) >>> (64 - DW);
    endfunction

    function automatic longint sliceOf(input longint d);
        longint s;
        s = d >>> (SEL_HI - 17);
        if (s > 131071) return 131071;
        if (s < -131072) return -131072;
        return s;
    endfunction

    function automatic int levelOf(input longint p);
        if (p >= (longint'(1) << (SQ_HI + 1))) return 63;
        for (int b = SQ_HI; b >= SQ_HI - 15; b--)
            if (p >= (longint'(1) << b)) return 4 * (b - (SQ_HI - 15)) + 2;
        return 0;
    endfunction

    function automatic logic [15:0] rgbOf(input int lv);
        int r, g, b;
`ifdef SPEC_HEAT_PALETTE_EN
        if (lv == 63) return 16'hFFFF;
        r = lv / 2;
        if (r > 31) r = 31;
        g = (lv >= 32) ? (lv % 32) * 2 : 0;
        b = (lv >= 32) ? 0 : lv % 32;
`else
        r = lv / 2;
        g = lv;
        b = lv / 2;
`endif
        return 16'(r * 2048 + g * 32 + b);
    endfunction

    function automatic void clearModel();
        pend.delete();
        for (int s = 0; s < NS; s++) primed[s] = 1'b0;
        expSlot  = 0;
        expPow   = 0;
        expLevel = 0;
        expRgb   = '0;
    endfunction

    // One clock: check what the design shows now, then present the next input.
    task automatic applyStimulus(input bit v, input int slot, input longint re, input longint im, input bit fl);
        longint wr, wi, sr, si;
        res_t   r;
        @(negedge CLK);
        cyc++;
        expValid = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r        = pend.pop_front();
            expValid = 1'b1;
            expSlot  = r.slot;
            expPow   = r.pow;
            expLevel = r.level;
            expRgb   = r.rgb;
        end
        checkOutput("out_valid", 64'(out_valid), 64'(expValid));
        checkOutput("out_slot", 64'(out_slot), 64'(expSlot[4:0]));
        checkOutput("out_pow", 64'(out_pow), 64'(expPow));
        checkOutput("out_level", 64'(out_level), 64'(expLevel));
        checkOutput("out_rgb565", 64'(out_rgb565), 64'(expRgb));

        in_valid = v;
        in_slot  = slot[4:0];
        in_re    = re[DW-1:0];
        in_im    = im[DW-1:0];
        flush    = fl;
        if (fl)
            for (int s = 0; s < NS; s++) primed[s] = 1'b0;
        if (v) begin
            wr = wrapDw(re);
            wi = wrapDw(im);
            if (primed[slot]) begin
                sr      = sliceOf(wrapDw(wr - memRe[slot]));
                si      = sliceOf(wrapDw(wi - memIm[slot]));
                r.due   = cyc + 4;
                r.slot  = slot;
                r.pow   = sr * sr + si * si;
                r.level = levelOf(r.pow);
                r.rgb   = rgbOf(r.level);
                pend.push_back(r);
            end
            memRe[slot]  = wr;
            memIm[slot]  = wi;
            primed[slot] = 1'b1;
        end
    endtask

    task automatic doReset();
        @(negedge CLK);
        cyc++;
        RST      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_slot", 64'(out_slot), 64'd0);
        checkOutput("rst_pow", 64'(out_pow), 64'd0);
        checkOutput("rst_level", 64'(out_level), 64'd0);
        checkOutput("rst_rgb", 64'(out_rgb565), 64'd0);
        clearModel();
        @(negedge CLK);
        cyc++;
        RST = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        longint base, delta, ri, ii;
        int     slot, sh;
        bit     v, fl;

        for (int s = 0; s < NS; s++) begin
            memRe[s] = 0;
            memIm[s] = 0;
        end
        clearModel();
        doReset();

        // Prime then saturating positive difference.
        applyStimulus(1'b1, 3, 0, 0, 1'b0);
        applyStimulus(1'b1, 3, longint'(1) << 41, 0, 1'b0);
        idle(5);
        applyStimulus(1'b1, 0, 0, 0, 1'b0);
        applyStimulus(1'b1, 0, longint'(1) << 50, 0, 1'b0);
        idle(5);

        // Back-to-back same slot exercises write forwarding.
        applyStimulus(1'b1, 5, 0, 0, 1'b0);
        applyStimulus(1'b1, 5, longint'(1) << 49, 0, 1'b0);
        applyStimulus(1'b1, 5, longint'(1) << 50, 0, 1'b0);
        applyStimulus(1'b1, 6, 0, 0, 1'b0);
        applyStimulus(1'b1, 6, longint'(1024) << 24, 0, 1'b0);
        applyStimulus(1'b1, 6, (longint'(1024) << 24) - (longint'(1) << 41), 0, 1'b0);
        applyStimulus(1'b1, 9, 0, 0, 1'b0);
        applyStimulus(1'b1, 9, longint'(724) << 24, longint'(724) << 24, 1'b0);
        applyStimulus(1'b1, 9, longint'(-300) << 24, longint'(1) << 24, 1'b0);
        idle(5);

        // Prime every slot, then flush together with a slot-7 sample.
        for (int s = 0; s < NS; s++)
            applyStimulus(1'b1, s, longint'($urandom_range(0, 65535)) << 20, longint'($urandom_range(0, 65535)) << 20, 1'b0);
        applyStimulus(1'b1, 7, longint'(5) << 30, 0, 1'b1);
        applyStimulus(1'b1, 7, longint'(77) << 30, longint'(-3) << 30, 1'b0);
        idle(6);

        // Mid-stream reset drops everything still in flight.
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, i, memRe[i] + (longint'(i + 1) << 33), memIm[i], 1'b0);
        doReset();
        idle(8);

        for (int i = 0; i < 500; i++) begin
            if (i == 250) doReset();
            v     = ($urandom_range(0, 3) != 0);
            fl    = ($urandom_range(0, 31) == 0);
            slot  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, NS - 1);
            sh    = $urandom_range(14, 44);
            delta = longint'($urandom_range(0, 2047)) - 1024;
            base  = memRe[slot];
            ri    = base + (delta <<< sh);
            delta = longint'($urandom_range(0, 2047)) - 1024;
            ii    = memIm[slot] + (delta <<< $urandom_range(14, 44));
            applyStimulus(v, slot, ri, ii, fl);
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
